// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder slice
// whose carry path is closed through a carry flip-flop. Operands are captured
// on start, the sum is produced LSB first over WIDTH cycles, then presented as
// a registered parallel word together with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input (a - b).

// Single-bit full adder slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  // The bit entering at the LSB end of a full-width sum shifter would be
  // shifted out unread on the final edge, so only the upper WIDTH-1 sum bits
  // are stored; the final slice output supplies the MSB of the result.
  logic [WIDTH-2:0]  s_sr_q, s_sr_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;

  logic              fa_s;
  logic              fa_c;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

  full_adder u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  // Operand-B and carry values loaded on start (two's-complement for subtract).
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load     = b;
    carry_load = cin;
  end
`endif

  // Next-state logic: capture in IDLE, one slice step per cycle in RUN.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (WIDTH > 2) begin
          s_sr_d = {fa_s, s_sr_q[WIDTH-2:1]};
        end else begin
          s_sr_d = fa_s;
        end
        carry_d = fa_c;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_s, s_sr_q};
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 instance for functional scenarios and a
// WIDTH=2 instance for the exhaustive sweep. Expected results come from plain
// integer arithmetic on the operands.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8;
  logic       sub2;
`endif

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int total;
  int bad;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub8),
`endif
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub2),
`endif
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: add is a+b+cin; subtract gives a-b with cout meaning no borrow.
  function automatic logic [8:0] model8(input logic [7:0] ai, input logic [7:0] bi,
                                        input logic ci, input logic si);
    int unsigned diff;
    if (si) begin
      diff = (int'(ai) - int'(bi)) & 32'hFF;
      return {(ai >= bi), diff[7:0]};
    end
    return 9'(int'(ai) + int'(bi) + int'(ci));
  endfunction

  // Runs one WIDTH=8 operation from IDLE and reports what was observed.
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                     input logic si, output logic [8:0] res, output int lat,
                     output bit busy_ok, output bit hold_ok, output logic done_after);
    logic [8:0] prev;
    prev   = {cout8, sum8};
    a8     = ai;
    b8     = bi;
    cin8   = ci;
`ifdef SERIAL_ADDER_SUB_EN
    sub8   = si;
`else
    if (si) $display("note: subtract requested without sub support");
`endif
    start8 = 1'b1;
    @(posedge clk); #1;
    start8  = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done8 !== 1'b1 && lat < 30) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      if ({cout8, sum8} !== prev) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy8 !== 1'b0) busy_ok = 1'b0;
    res = {cout8, sum8};
    @(posedge clk); #1;
    done_after = done8;
  endtask

  task automatic test_reset_values;
    rst_n = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub2 = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #6;
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'b0) begin
      bad++;
      $display("FAIL reset_values got busy=%b done=%b cout=%b sum=%h exp all 0",
               busy8, done8, cout8, sum8);
    end
    total++;
    if ({busy2, done2, cout2, sum2} !== 5'b0) begin
      bad++;
      $display("FAIL reset_values_w2 got busy=%b done=%b cout=%b sum=%h exp all 0",
               busy2, done2, cout2, sum2);
    end
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [8:0] res; int lat; bit bok, hok; logic da;
    op8(8'h5A, 8'h33, 1'b0, 1'b0, res, lat, bok, hok, da);
    total++;
    if (res !== 9'h08D) begin
      bad++; $display("FAIL basic_result got %h exp %h", res, 9'h08D);
    end
    total++;
    if (lat !== 8) begin
      bad++; $display("FAIL basic_latency got %0d exp 8", lat);
    end
    total++;
    if (!bok) begin
      bad++; $display("FAIL basic_busy got bad busy window exp high T0..T8 only");
    end
    total++;
    if (da !== 1'b0) begin
      bad++; $display("FAIL basic_done_pulse got done=%b after T9 exp 0", da);
    end
  endtask

  task automatic test_carry;
    logic [8:0] res; int lat; bit bok, hok; logic da;
    op8(8'hFF, 8'h01, 1'b0, 1'b0, res, lat, bok, hok, da);
    total++;
    if (res !== 9'h100) begin
      bad++; $display("FAIL carry_ff_01 got %h exp %h", res, 9'h100);
    end
    total++;
    if (!hok) begin
      bad++; $display("FAIL carry_hold got sum/cout changed during RUN exp held");
    end
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, res, lat, bok, hok, da);
    total++;
    if (res !== 9'h1FF) begin
      bad++; $display("FAIL carry_ff_ff_1 got %h exp %h", res, 9'h1FF);
    end
  endtask

  task automatic test_reset_midop;
    logic [8:0] res; int lat; bit bok, hok; logic da;
    int ndone;
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'b0) begin
      bad++;
      $display("FAIL reset_midop got busy=%b done=%b cout=%b sum=%h exp all 0",
               busy8, done8, cout8, sum8);
    end
    #12 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++; $display("FAIL reset_no_done got %0d active cycles exp 0", ndone);
    end
    op8(8'h12, 8'h34, 1'b1, 1'b0, res, lat, bok, hok, da);
    total++;
    if (res !== 9'h047 || lat !== 8) begin
      bad++; $display("FAIL reset_recover got %h lat=%0d exp 047 lat=8", res, lat);
    end
  endtask

  task automatic test_back_to_back;
    int first_k, second_k, ndone;
    logic [8:0] r1, r2;
    bit overlap;
    first_k = -1; second_k = -1; ndone = 0; overlap = 1'b0;
    r1 = '0; r2 = '0;
    a8 = 8'h81; b8 = 8'h92; cin8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0;
`endif
    start8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy8 === 1'b1 && done8 === 1'b1) overlap = 1'b1;
      if (done8 === 1'b1) begin
        ndone++;
        if (ndone == 1) begin first_k = k; r1 = {cout8, sum8}; end
        if (ndone == 2) begin second_k = k; r2 = {cout8, sum8}; end
      end
      if (k == 3) begin a8 = 8'h0C; b8 = 8'h07; cin8 = 1'b0; end
      if (k == 9) begin
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b1) begin
          bad++; $display("FAIL b2b_accept got busy=%b at T9 exp 1", busy8);
        end
      end
    end
    total++;
    if (first_k !== 8 || second_k !== 17 || ndone !== 2) begin
      bad++;
      $display("FAIL b2b_timing got done at %0d,%0d count=%0d exp 8,17 count=2",
               first_k, second_k, ndone);
    end
    total++;
    if (r1 !== model8(8'h81, 8'h92, 1'b1, 1'b0)) begin
      bad++; $display("FAIL b2b_first got %h exp %h", r1, model8(8'h81, 8'h92, 1'b1, 1'b0));
    end
    total++;
    if (r2 !== model8(8'h0C, 8'h07, 1'b0, 1'b0)) begin
      bad++; $display("FAIL b2b_second got %h exp %h", r2, model8(8'h0C, 8'h07, 1'b0, 1'b0));
    end
    total++;
    if (overlap) begin
      bad++; $display("FAIL b2b_busy_done got busy and done together exp never");
    end
  endtask

  task automatic test_random;
    logic [8:0] res, exp; int lat; bit bok, hok; logic da;
    logic [7:0] ra, rb; logic rc, rs;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp = model8(ra, rb, rc, rs);
      op8(ra, rb, rc, rs, res, lat, bok, hok, da);
      total++;
      if (res !== exp || lat !== 8 || !bok || !hok || da !== 1'b0) begin
        bad++;
        $display("FAIL random a=%h b=%h cin=%b sub=%b got %h lat=%0d busy_ok=%0d hold_ok=%0d exp %h lat=8",
                 ra, rb, rc, rs, res, lat, bok, hok, exp);
      end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [8:0] res; int lat; bit bok, hok; logic da;
    op8(8'h10, 8'h01, 1'b0, 1'b1, res, lat, bok, hok, da);
    total++;
    if (res !== 9'h10F) begin
      bad++; $display("FAIL sub_10_01 got %h exp %h", res, 9'h10F);
    end
    op8(8'h01, 8'h02, 1'b1, 1'b1, res, lat, bok, hok, da);
    total++;
    if (res !== 9'h0FF) begin
      bad++; $display("FAIL sub_01_02 got %h exp %h", res, 9'h0FF);
    end
  endtask
`endif

  task automatic test_exhaustive_w2;
    logic [2:0] exp;
    int lat;
    for (int unsigned v = 0; v < 32; v++) begin
      a2   = v[1:0];
      b2   = v[3:2];
      cin2 = v[4];
      exp  = 3'(a2) + 3'(b2) + 3'(cin2);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      lat = 0;
      while (done2 !== 1'b1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if ({cout2, sum2} !== exp || lat !== 2) begin
        bad++;
        $display("FAIL exhaustive_w2 a=%0d b=%0d cin=%0d got %0d lat=%0d exp %0d lat=2",
                 a2, b2, cin2, {cout2, sum2}, lat, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset_values();
    test_basic();
    test_carry();
    test_reset_midop();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_exhaustive_w2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that sits directly downstream of the single-bit full adder. It instantiates one full-adder slice and closes its carry path through a carry flip-flop, so one slice performs a multi-bit add over WIDTH clock cycles, LSB first. Operands are captured on a start request. The result is presented as a registered parallel word with a one-cycle done pulse.

## Interface
- WIDTH, 8: operand and sum width in bits; WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle onward.
- sum  output  WIDTH  registered result of the last completed operation.
- cout  output  1  registered carry-out of the last completed operation.

## Operation
- Internal state:
  - a_sr and b_sr: WIDTH-bit right-shift registers for the operands.
  - s_sr: WIDTH-bit shift register for sum bits; each new bit enters at the MSB.
  - carry: carry flip-flop.
  - cnt: bit counter, $clog2(WIDTH) bits.
  - state: two states, IDLE and RUN.
- IDLE, start=1 at a rising edge:
  - a_sr <= a, b_sr <= b, carry <= cin, cnt <= 0.
  - state -> RUN.
- IDLE, start=0: hold all registers.
- RUN, every edge:
  - The full-adder slice computes from a_sr[0], b_sr[0] and carry.
  - The slice's S bit is shifted into s_sr[WIDTH-1]; its C bit is loaded into carry.
  - a_sr and b_sr shift right by one; cnt increments.
- RUN, at the edge where cnt == WIDTH-1:
  - sum <= {S, s_sr[WIDTH-1:1]} and cout <= C.
  - done <= 1.
  - state -> IDLE.
- done is cleared at the next edge.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). There is no overflow flag.
- start in RUN is ignored, as are a, b and cin changes. The operation in flight is unaffected.
- start held high continuously gives back-to-back operations, one per WIDTH+1 cycles.
- sum and cout hold their value until the next operation completes; they do not change during RUN.

## Timing
- Reset values (asynchronous, while rst_n=0): state=IDLE, busy=0, done=0, sum=0, cout=0. a_sr, b_sr, s_sr, carry and cnt are all 0.
- Reset mid-operation: aborts immediately. No done pulse is produced, and sum/cout are cleared to 0.
- start accepted at edge T0:
  - busy is high from T0 to T(WIDTH).
  - done is high from T(WIDTH) to T(WIDTH+1).
  - sum and cout are valid from T(WIDTH).
- Latency is WIDTH cycles from the start edge to done.
- The earliest next start is accepted at edge T(WIDTH+1).
- busy and done are never high together.
- The datapath critical path is one full-adder slice plus the shift-register muxing. It is independent of WIDTH.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - The sub input exists and is captured together with the operands.
  - When sub=1: b_sr <= ~b and carry <= 1, and cin is ignored. The result is sum = a - b.
  - With sub=1, cout=1 means no borrow (a >= b unsigned).
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: there is no sub port, and the block always adds.

## Test plan
- Reset: drop rst_n at the 4th RUN cycle of an add with WIDTH=8 -> busy, done, sum and cout go to 0 immediately. No done pulse appears after release, and the next start completes normally.
- Basic add, WIDTH=8: a=8'h5A, b=8'h33, cin=0, start at T0 -> done only between T8 and T9, sum=8'h8D, cout=0, busy high T0–T8.
- Carry chain:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start while busy, with start held high and operands changed at T3 -> the first result uses the T0 operands. The second operation is accepted at T9 and its done arrives at T17.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - a=8'h01, b=8'h02 -> sum=8'hFF, cout=0.
- Exhaustive, WIDTH=2: all 32 combinations of a, b and cin -> every {cout, sum} equals a+b+cin, and done appears exactly 2 cycles after each start.
